// File: rtl/rr_mux_arb_if.sv
// Handshake bundle between NCH parallel producers, the arbiter and one consumer.
interface rr_mux_arb_if #(
   parameter int unsigned NCH   = 8,
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned SW = $clog2(NCH);
   localparam int unsigned CW = 16;

   logic [NCH-1:0]       in_valid;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_ready;
   logic                 force_en;
   logic [SW-1:0]        s;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_data;
   logic [SW-1:0]        out_ch;
   logic [CW-1:0]        xfer_cnt;

   // Arbiter side
   modport slave (
      input  in_valid, in_data, force_en, s, out_ready,
      output in_ready, out_valid, out_data, out_ch, xfer_cnt
   );

   // Producer/consumer side
   modport master (
      output in_valid, in_data, force_en, s, out_ready,
      input  in_ready, out_valid, out_data, out_ch, xfer_cnt
   );
endinterface

// File: rtl/rr_mux_arb.sv
// NCH-to-1 streaming merge with round-robin or fixed-priority arbitration,
// a run-time forced select, and a registered valid/ready output stage.
module rr_mux_arb #(
   parameter int unsigned NCH   = 8,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned MODE  = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   rr_mux_arb_if.slave bus
);
   localparam int unsigned SW = $clog2(NCH);
   localparam int unsigned CW = 16;

   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [SW-1:0]    out_ch_q;
   logic [SW-1:0]    last_ptr;
   logic [CW-1:0]    xfer_cnt_q;

   logic             load_en_c;
   logic             hi_vld_c;
   logic [SW-1:0]    hi_idx_c;
   logic             lo_vld_c;
   logic [SW-1:0]    lo_idx_c;
   logic             gnt_vld_c;
   logic [SW-1:0]    gnt_idx_c;
   logic [WIDTH-1:0] gnt_data_c;

   // Output register can take new data when empty or draining this cycle
   assign load_en_c = !out_valid_q || bus.out_ready;

   // Lowest valid channel overall, and lowest valid channel above last grant
   always_comb begin
      hi_vld_c = 1'b0;
      hi_idx_c = '0;
      lo_vld_c = 1'b0;
      lo_idx_c = '0;
      for (int k = int'(NCH) - 1; k >= 0; k--) begin
         if (bus.in_valid[k]) begin
            lo_vld_c = 1'b1;
            lo_idx_c = SW'(k);
            if (SW'(k) > last_ptr) begin
               hi_vld_c = 1'b1;
               hi_idx_c = SW'(k);
            end
         end
      end
   end

   // Grant select: forced channel, fixed priority, or round-robin with wrap
   always_comb begin
      gnt_vld_c = 1'b0;
      gnt_idx_c = '0;
      if (bus.force_en) begin
         for (int k = 0; k < int'(NCH); k++) begin
            if (bus.s == SW'(k) && bus.in_valid[k]) begin
               gnt_vld_c = 1'b1;
               gnt_idx_c = SW'(k);
            end
         end
      end else if (MODE == 1) begin
         gnt_vld_c = lo_vld_c;
         gnt_idx_c = lo_idx_c;
      end else if (hi_vld_c) begin
         gnt_vld_c = 1'b1;
         gnt_idx_c = hi_idx_c;
      end else begin
         gnt_vld_c = lo_vld_c;
         gnt_idx_c = lo_idx_c;
      end
   end

   // Data of the granted channel
   always_comb begin
      gnt_data_c = '0;
      for (int k = 0; k < int'(NCH); k++) begin
         if (gnt_idx_c == SW'(k)) begin
            gnt_data_c = bus.in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // One-hot accept back to the granted producer
   always_comb begin
      bus.in_ready = '0;
      if (load_en_c && gnt_vld_c) begin
         bus.in_ready[gnt_idx_c] = 1'b1;
      end
   end

   // Output register and last-grant pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         last_ptr    <= SW'(NCH - 1);
      end else if (load_en_c) begin
         if (gnt_vld_c) begin
            out_valid_q <= 1'b1;
            out_data_q  <= gnt_data_c;
            out_ch_q    <= gnt_idx_c;
            last_ptr    <= gnt_idx_c;
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Completed output transfer counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt_q <= '0;
      end else if (out_valid_q && bus.out_ready) begin
         xfer_cnt_q <= xfer_cnt_q + CW'(1);
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.xfer_cnt  = xfer_cnt_q;
endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb: vector table plus scoreboard on the 8-channel
// round-robin instance, hand sequences for priority, stall, reset and sweeps.
module tb_rr_mux_arb;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   rr_mux_arb_if #(.NCH(8), .WIDTH(8))  b0 ();
   rr_mux_arb_if #(.NCH(8), .WIDTH(8))  b1 ();
   rr_mux_arb_if #(.NCH(5), .WIDTH(12)) b2 ();
   rr_mux_arb_if #(.NCH(2), .WIDTH(1))  b3 ();

   rr_mux_arb #(.NCH(8), .WIDTH(8),  .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   rr_mux_arb #(.NCH(8), .WIDTH(8),  .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   rr_mux_arb #(.NCH(5), .WIDTH(12), .MODE(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
   rr_mux_arb #(.NCH(2), .WIDTH(1),  .MODE(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

   typedef struct packed {
      logic [3:0] ch;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      logic [7:0] vld;
      logic       fe;
      logic [2:0] s;
      logic       rdy;
      logic [7:0] exp_rdy;
   } vec_t;

   exp_t       sb[$];
   vec_t       tbl[34];
   logic [7:0] dat0[8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] vld, input logic fe, input logic [2:0] s,
                               input logic rdy, input logic [7:0] er);
      vec_t v;
      v.vld = vld; v.fe = fe; v.s = s; v.rdy = rdy; v.exp_rdy = er;
      return v;
   endfunction

   // One cycle on u0: drive at negedge, check accept, score transfers, return after posedge
   task automatic step0(input vec_t v, input string name);
      exp_t e;
      @(negedge clk);
      b0.in_valid  = v.vld;
      b0.force_en  = v.fe;
      b0.s         = v.s;
      b0.out_ready = v.rdy;
      for (int k = 0; k < 8; k++) b0.in_data[k*8 +: 8] = dat0[k];
      #1;
      chk({name, " in_ready"}, 32'(b0.in_ready), 32'(v.exp_rdy));
      if (b0.out_valid && b0.out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s transfer: got ch %0d, want no queued item", name, b0.out_ch);
         end else begin
            e = sb.pop_front();
            chk({name, " out_ch"},   32'(b0.out_ch),   32'(e.ch));
            chk({name, " out_data"}, 32'(b0.out_data), 32'(e.data));
         end
      end
      for (int k = 0; k < 8; k++) begin
         if (v.exp_rdy[k]) sb.push_back('{ch: 4'(k), data: dat0[k]});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      for (int k = 0; k < 8; k++) dat0[k] = 8'(8'h10 + k);
      b0.in_valid = '0; b0.in_data = '0; b0.force_en = 1'b0; b0.s = '0; b0.out_ready = 1'b0;
      b1.in_valid = '0; b1.in_data = '0; b1.force_en = 1'b0; b1.s = '0; b1.out_ready = 1'b0;
      b2.in_valid = '0; b2.in_data = '0; b2.force_en = 1'b0; b2.s = '0; b2.out_ready = 1'b0;
      b3.in_valid = '0; b3.in_data = '0; b3.force_en = 1'b0; b3.s = '0; b3.out_ready = 1'b0;
      for (int k = 0; k < 8; k++) b1.in_data[k*8 +: 8] = dat0[k];
      for (int k = 0; k < 5; k++) b2.in_data[k*12 +: 12] = 12'(12'h100 + k);
      b3.in_data = 2'b10;

      // Vector table for u0
      for (int i = 0; i < 9; i++) tbl[i] = mk(8'hFF, 1'b0, 3'd0, 1'b1, 8'(1 << (i % 8)));
      tbl[9]  = mk(8'h92, 1'b0, 3'd0, 1'b1, 8'h02);
      tbl[10] = mk(8'h92, 1'b0, 3'd0, 1'b1, 8'h10);
      tbl[11] = mk(8'h92, 1'b0, 3'd0, 1'b1, 8'h80);
      tbl[12] = mk(8'h92, 1'b0, 3'd0, 1'b1, 8'h02);
      tbl[13] = mk(8'h00, 1'b0, 3'd0, 1'b1, 8'h00);
      for (int i = 14; i < 17; i++) tbl[i] = mk(8'h08, 1'b0, 3'd0, 1'b1, 8'h08);
      for (int i = 0; i < 16; i++) tbl[17+i] = mk(8'hFF, 1'b1, 3'(i / 2), 1'b1, 8'(1 << (i / 2)));
      tbl[33] = mk(8'hBF, 1'b1, 3'd6, 1'b1, 8'h00);

      // Reset values
      #2;
      chk("rst out_valid", 32'(b0.out_valid), 32'd0);
      chk("rst out_data",  32'(b0.out_data),  32'd0);
      chk("rst out_ch",    32'(b0.out_ch),    32'd0);
      chk("rst xfer_cnt",  32'(b0.xfer_cnt),  32'd0);
      #10 rst_n = 1'b1;

      // Round-robin order, patterns, drain, single channel, forced select
      for (int i = 0; i < 34; i++) begin
         step0(tbl[i], $sformatf("v%0d", i));
         if (i == 8) chk("rr xfer_cnt", 32'(b0.xfer_cnt), 32'd8);
      end
      chk("force s6 idle out_valid", 32'(b0.out_valid), 32'd0);
      chk("table xfer_cnt", 32'(b0.xfer_cnt), 32'd32);

      // Back-pressure on channel 3
      dat0[3] = 8'hA5;
      step0(mk(8'h08, 1'b0, 3'd0, 1'b1, 8'h08), "bp load");
      for (int i = 0; i < 4; i++) begin
         step0(mk(8'h08, 1'b0, 3'd0, 1'b0, 8'h00), $sformatf("bp stall%0d", i));
         chk("bp out_valid", 32'(b0.out_valid), 32'd1);
         chk("bp out_data",  32'(b0.out_data),  32'hA5);
         chk("bp out_ch",    32'(b0.out_ch),    32'd3);
      end
      step0(mk(8'h00, 1'b0, 3'd0, 1'b1, 8'h00), "bp release");
      chk("bp drained", 32'(b0.out_valid), 32'd0);
      chk("bp xfer_cnt", 32'(b0.xfer_cnt), 32'd33);
      step0(mk(8'h00, 1'b0, 3'd0, 1'b1, 8'h00), "bp idle");
      chk("bp xfer_cnt once", 32'(b0.xfer_cnt), 32'd33);
      dat0[3] = 8'h13;

      // Asynchronous reset between edges
      step0(mk(8'hFF, 1'b0, 3'd0, 1'b1, 8'h10), "ar0");
      step0(mk(8'hFF, 1'b0, 3'd0, 1'b1, 8'h20), "ar1");
      #2;
      rst_n = 1'b0;
      b0.in_valid = '0;
      #1;
      chk("arst out_valid", 32'(b0.out_valid), 32'd0);
      chk("arst out_data",  32'(b0.out_data),  32'd0);
      chk("arst out_ch",    32'(b0.out_ch),    32'd0);
      chk("arst xfer_cnt",  32'(b0.xfer_cnt),  32'd0);
      sb.delete();
      #2 rst_n = 1'b1;
      step0(mk(8'hFF, 1'b0, 3'd0, 1'b1, 8'h01), "ar first");
      step0(mk(8'hFF, 1'b0, 3'd0, 1'b1, 8'h02), "ar second");
      b0.in_valid = '0;

      // Fixed priority on u1
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); b1.in_valid = 8'hA4; b1.out_ready = 1'b1;
         #1 chk("fp in_ready", 32'(b1.in_ready), 32'h04);
         @(posedge clk); #1 chk("fp out_ch", 32'(b1.out_ch), 32'd2);
      end
      @(negedge clk); b1.in_valid = 8'hA0;
      #1 chk("fp5 in_ready", 32'(b1.in_ready), 32'h20);
      @(posedge clk); #1 chk("fp5 out_ch", 32'(b1.out_ch), 32'd5);
      chk("fp5 out_data", 32'(b1.out_data), 32'h15);
      @(negedge clk); b1.in_valid = 8'h80;
      #1 chk("fp7 in_ready", 32'(b1.in_ready), 32'h80);
      @(posedge clk); #1 chk("fp7 out_ch", 32'(b1.out_ch), 32'd7);
      b1.in_valid = '0;

      // NCH=5: round-robin wrap 4->0, out-of-range forced select
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); b2.in_valid = 5'h1F; b2.force_en = 1'b0; b2.out_ready = 1'b1;
         #1 chk("n5 in_ready", 32'(b2.in_ready), 32'(1 << (i % 5)));
         @(posedge clk); #1;
         chk("n5 out_ch",   32'(b2.out_ch),   32'(i % 5));
         chk("n5 out_data", 32'(b2.out_data), 32'(12'h100 + i % 5));
      end
      for (int i = 5; i < 8; i++) begin
         @(negedge clk); b2.force_en = 1'b1; b2.s = 3'(i);
         #1 chk($sformatf("n5 s%0d in_ready", i), 32'(b2.in_ready), 32'd0);
         @(posedge clk); #1 chk($sformatf("n5 s%0d out_valid", i), 32'(b2.out_valid), 32'd0);
      end
      chk("n5 xfer_cnt", 32'(b2.xfer_cnt), 32'd6);
      @(negedge clk); b2.s = 3'd2;
      #1 chk("n5 s2 in_ready", 32'(b2.in_ready), 32'h04);
      @(posedge clk); #1 chk("n5 s2 out_ch", 32'(b2.out_ch), 32'd2);
      b2.in_valid = '0;

      // NCH=2, WIDTH=1: wrap 1->0
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); b3.in_valid = 2'b11; b3.out_ready = 1'b1;
         #1 chk("n2 in_ready", 32'(b3.in_ready), 32'(1 << (i % 2)));
         @(posedge clk); #1;
         chk("n2 out_ch",   32'(b3.out_ch),   32'(i % 2));
         chk("n2 out_data", 32'(b3.out_data), 32'(i % 2));
      end

      // 65536 forced transfers bring xfer_cnt back to 0
      @(negedge clk);
      b3.force_en = 1'b1; b3.s = 1'b1; b3.in_valid = 2'b10;
      #1 rst_n = 1'b0;
      #1 chk("n2 rst xfer_cnt", 32'(b3.xfer_cnt), 32'd0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      repeat (65535) @(posedge clk);
      #1 chk("wrap max", 32'(b3.xfer_cnt), 32'hFFFF);
      @(posedge clk);
      #1 chk("wrap zero", 32'(b3.xfer_cnt), 32'd0);
      chk("wrap out_ch", 32'(b3.out_ch), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
